// File: rtl/midi_decode_if.sv
// MIDI decoder byte-in / note-out bundle.
// Master drives bytes, slave emits note events.
interface midi_decode_if;
  logic [7:0] byte_in;
  logic       byte_valid_in;
  logic [7:0] midi_velocity_out;
  logic [7:0] midi_received_note_out;
  logic [3:0] midi_channel_out;
  logic       midi_status_out;
  logic       midi_data_ready_out;

  modport master (
    output byte_in,
    output byte_valid_in,
    input  midi_velocity_out,
    input  midi_received_note_out,
    input  midi_channel_out,
    input  midi_status_out,
    input  midi_data_ready_out
  );

  modport slave (
    input  byte_in,
    input  byte_valid_in,
    output midi_velocity_out,
    output midi_received_note_out,
    output midi_channel_out,
    output midi_status_out,
    output midi_data_ready_out
  );
endinterface

// File: rtl/midi_decode.sv
// MIDI byte parser with running status.
// Emits one event per Note On / Note Off message.
module midi_decode #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input logic          clk_in,
  input logic          rst_in,
  midi_decode_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SYSEX
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] run_q, run_d;
  logic [6:0] d1_q, d1_d;
  logic       emit;

  logic [7:0] b;
  logic       is_rt, is_sx, is_sc;
  logic       is_cs, is_dat;
  logic       one_byte, note_msg, ch_ok;

  assign b      = bus.byte_in;
  assign is_rt  = b[7:3] == 5'b11111;
  assign is_sx  = b == 8'hF0;
  assign is_sc  = b[7:4] == 4'hF
               && !is_rt && !is_sx;
  assign is_cs  = b[7] && b[7:4] != 4'hF;
  assign is_dat = !b[7];

  // 0xC/0xD carry one data byte
  assign one_byte = run_q[7:5] == 3'b110;
  // 0x8/0x9 are the only note messages
  assign note_msg = run_q[7:5] == 3'b100;
  assign ch_ok    = OMNI
                 || run_q[3:0] == CHANNEL;

  // Next-state: classify byte, advance parser
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    d1_d    = d1_q;
    emit    = 1'b0;
    if (bus.byte_valid_in) begin
      unique case (1'b1)
        is_rt: begin
        end
        is_sx: begin
          state_d = SYSEX;
          run_d   = '0;
        end
        is_sc: begin
          state_d = IDLE;
          run_d   = '0;
        end
        is_cs: begin
          state_d = WAIT_D1;
          run_d   = b;
        end
        is_dat: begin
          unique case (state_q)
            WAIT_D1: begin
              d1_d    = b[6:0];
              state_d = one_byte
                      ? WAIT_D1
                      : WAIT_D2;
            end
            WAIT_D2: begin
              emit    = note_msg && ch_ok;
              state_d = WAIT_D1;
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  // State, running status and note outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      run_q   <= '0;
      d1_q    <= '0;
      bus.midi_data_ready_out    <= 1'b0;
      bus.midi_velocity_out      <= '0;
      bus.midi_received_note_out <= '0;
      bus.midi_channel_out       <= '0;
      bus.midi_status_out        <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      d1_q    <= d1_d;
      bus.midi_data_ready_out <= emit;
      if (emit) begin
        bus.midi_velocity_out <=
          {1'b0, b[6:0]};
        bus.midi_received_note_out <=
          {1'b0, d1_q};
        bus.midi_channel_out <= run_q[3:0];
        bus.midi_status_out  <=
          run_q[4] && (b[6:0] != 7'd0);
      end
    end
  end

endmodule
